// File: rtl/cic_rate_ctrl_pkg.sv
// cic_rate_ctrl_pkg: shared types and constants for the CIC rate sequencer.
// Holds the FSM state encoding, the drop counter width and the counter sizer.
package cic_rate_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BND = 3'd1,
    HOLD     = 3'd2,
    APPLY    = 3'd3,
    SETTLE   = 3'd4
  } state_e;

  localparam int DROP_W = 16;

  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cic_sat_counter.sv
// cic_sat_counter: saturating up-counter with synchronous clear and enable.
// Ports: clk, rst_n (async low), clr_i, en_i, cnt_o[W-1:0].
module cic_sat_counter
  import cic_rate_ctrl_pkg::*;
#(
  parameter int W = DROP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cic_rate_ctrl.sv
// cic_rate_ctrl: run-time rate sequencer for the variable-rate CIC decimator.
// Ports: cfg AXIS in (tdata/tvalid/tready), cfg_err, in/out valid gates,
//   rate AXIS out, current_rate, busy, drop_cnt; timeout_evt only when
//   CIC_RATE_CTRL_TIMEOUT_EN is defined (bounded boundary wait).
module cic_rate_ctrl
  import cic_rate_ctrl_pkg::*;
#(
  parameter int RATE_DW     = 32,
  parameter int R_MIN       = 2,
  parameter int R_MAX       = 10,
  parameter int HOLD_CYC    = 4,
  parameter int SETTLE_CNT  = 7,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [RATE_DW-1:0] s_axis_cfg_tdata,
  input  logic               s_axis_cfg_tvalid,
  output logic               s_axis_cfg_tready,
  output logic               cfg_err,
  input  logic               in_tvalid_i,
  output logic               in_tvalid_o,
  input  logic               cic_out_tvalid_i,
  output logic               out_tvalid_o,
  output logic [RATE_DW-1:0] m_axis_rate_tdata,
  output logic               m_axis_rate_tvalid,
  output logic [RATE_DW-1:0] current_rate,
  output logic               busy,
`ifdef CIC_RATE_CTRL_TIMEOUT_EN
  output logic               timeout_evt,
`endif
  output logic [DROP_W-1:0]  drop_cnt
);

  localparam int CW = cnt_width(HOLD_CYC, SETTLE_CNT, TIMEOUT_CYC);
  localparam logic [RATE_DW-1:0] RMIN_V = RATE_DW'(R_MIN);
  localparam logic [RATE_DW-1:0] RMAX_V = RATE_DW'(R_MAX);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RATE_DW-1:0] pend_q, pend_d;
  logic [RATE_DW-1:0] rate_q, rate_d;
  logic               tready_q;
  logic               err_q, err_d;
  logic               hs;
  logic               bad;
`ifdef CIC_RATE_CTRL_TIMEOUT_EN
  logic               tout_q, tout_d;
`endif

  assign hs  = s_axis_cfg_tvalid & tready_q;
  assign bad = (s_axis_cfg_tdata < RMIN_V) |
               (s_axis_cfg_tdata > RMAX_V);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    rate_d  = rate_q;
    err_d   = 1'b0;
`ifdef CIC_RATE_CTRL_TIMEOUT_EN
    tout_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          if (bad) begin
            err_d = 1'b1;
          end else if (s_axis_cfg_tdata != rate_q) begin
            pend_d  = s_axis_cfg_tdata;
            cnt_d   = '0;
            state_d = WAIT_BND;
          end
        end
      end
      WAIT_BND: begin
        if (cic_out_tvalid_i) begin
          cnt_d   = CW'(HOLD_CYC - 1);
          state_d = HOLD;
`ifdef CIC_RATE_CTRL_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          cnt_d   = CW'(HOLD_CYC - 1);
          tout_d  = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          // rate register flips as APPLY begins, so the
          // load pulse and current_rate agree in that cycle
          rate_d  = pend_q;
          state_d = APPLY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      APPLY: begin
        if (SETTLE_CNT == 0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CW'(SETTLE_CNT);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cic_out_tvalid_i) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= RMAX_V;
      rate_q   <= RMAX_V;
      tready_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      rate_q   <= rate_d;
      tready_q <= (state_d == IDLE);
      err_q    <= err_d;
    end
  end

`ifdef CIC_RATE_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tout_q <= 1'b0;
    else          tout_q <= tout_d;
  end
  assign timeout_evt = tout_q;
`endif

  cic_sat_counter #(
    .W(DROP_W)
  ) u_drop (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (1'b0),
    .en_i  ((state_q == HOLD) & in_tvalid_i),
    .cnt_o (drop_cnt)
  );

  assign s_axis_cfg_tready  = tready_q;
  assign cfg_err            = err_q;
  assign in_tvalid_o        = in_tvalid_i & (state_q != HOLD);
  assign out_tvalid_o       = cic_out_tvalid_i & (state_q != SETTLE);
  assign m_axis_rate_tdata  = rate_q;
  assign m_axis_rate_tvalid = (state_q == APPLY);
  assign current_rate       = rate_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// tb_cic_rate_ctrl: directed scoreboard bench for cic_rate_ctrl.
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_cic_rate_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        cfg_err;
  logic        in_tvalid_i;
  logic        in_tvalid_o;
  logic        cic_out_tvalid_i;
  logic        out_tvalid_o;
  logic [31:0] m_axis_rate_tdata;
  logic        m_axis_rate_tvalid;
  logic [31:0] current_rate;
  logic        busy;
  logic [15:0] drop_cnt;
`ifdef CIC_RATE_CTRL_TIMEOUT_EN
  logic        timeout_evt;
`endif

  cic_rate_ctrl dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .s_axis_cfg_tdata   (s_tdata),
    .s_axis_cfg_tvalid  (s_tvalid),
    .s_axis_cfg_tready  (s_tready),
    .cfg_err            (cfg_err),
    .in_tvalid_i        (in_tvalid_i),
    .in_tvalid_o        (in_tvalid_o),
    .cic_out_tvalid_i   (cic_out_tvalid_i),
    .out_tvalid_o       (out_tvalid_o),
    .m_axis_rate_tdata  (m_axis_rate_tdata),
    .m_axis_rate_tvalid (m_axis_rate_tvalid),
    .current_rate       (current_rate),
    .busy               (busy),
`ifdef CIC_RATE_CTRL_TIMEOUT_EN
    .timeout_evt        (timeout_evt),
`endif
    .drop_cnt           (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    int          c;
  } rexp_t;

  rexp_t rate_q[$];
  int    err_q[$];
  bit    in_q[$];
  bit    out_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cic_pulse(input bit pass);
    out_q.push_back(pass);
    cic_out_tvalid_i = 1'b1;
    tick();
    cic_out_tvalid_i = 1'b0;
  endtask

  task automatic req(input logic [31:0] r, output int hs);
    hs       = -1;
    s_tdata  = r;
    s_tvalid = 1'b1;
    for (int i = 0; i < 200 && hs < 0; i++) begin
      if (s_tready) hs = cyc;
      tick();
    end
    s_tvalid = 1'b0;
    if (hs < 0) chk("req_accept_timeout", 32'd0, 32'd1);
  endtask

  // monitor: pops expectations whenever the DUT presents an event
  initial begin
    rexp_t e;
    int    ec;
    bit    b;
    forever begin
      @(negedge clk);
      if (m_axis_rate_tvalid) begin
        if (rate_q.size() == 0) begin
          chk("unexpected_rate_pulse", m_axis_rate_tdata, 32'd0);
        end else begin
          e = rate_q.pop_front();
          chk("rate_tdata", m_axis_rate_tdata, e.r);
          chk("rate_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (cfg_err) begin
        if (err_q.size() == 0) begin
          chk("unexpected_cfg_err", 32'd1, 32'd0);
        end else begin
          ec = err_q.pop_front();
          chk("cfg_err_cycle", 32'(cyc), 32'(ec));
        end
      end
      if (cic_out_tvalid_i) begin
        b = (out_q.size() != 0) ? out_q.pop_front() : 1'b1;
        chk("out_gate", 32'(out_tvalid_o), 32'(b));
      end
      if (in_tvalid_i) begin
        b = (in_q.size() != 0) ? in_q.pop_front() : 1'b1;
        chk("in_gate", 32'(in_tvalid_o), 32'(b));
      end
    end
  end

  initial begin
    int h;
    int b;
    int tc;
    reset_n          = 1'b0;
    s_tdata          = '0;
    s_tvalid         = 1'b0;
    in_tvalid_i      = 1'b0;
    cic_out_tvalid_i = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_cur_rate", current_rate, 32'd10);
    chk("rst_rate_tdata", m_axis_rate_tdata, 32'd10);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_rate_tvalid", 32'(m_axis_rate_tvalid), 32'd0);
    reset_n = 1'b1;
    chk("rel_tready_pre", 32'(s_tready), 32'd0);
    tick();
    chk("rel_tready_post", 32'(s_tready), 32'd1);
    in_q.push_back(1'b1);
    in_tvalid_i = 1'b1;
    tick();
    in_tvalid_i = 1'b0;
    cic_pulse(1'b1);

    // out-of-range requests
    req(32'd1, h);
    err_q.push_back(h + 1);
    req(32'd11, h);
    err_q.push_back(h + 1);
    tick();
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_cur_rate", current_rate, 32'd10);

    // same-rate no-op
    req(32'd10, h);
    chk("noop_busy", 32'(busy), 32'd0);
    chk("noop_tready", 32'(s_tready), 32'd1);
    tick();
    chk("noop_cur_rate", current_rate, 32'd10);

    // change to 5, outputs every 10 cycles
    req(32'd5, h);
    chk("r5_busy", 32'(busy), 32'd1);
    chk("r5_tready", 32'(s_tready), 32'd0);
    repeat (3) tick();
    b = cyc;
    rate_q.push_back('{32'd5, b + 5});
    cic_pulse(1'b1);
    for (int k = 1; k <= 8; k++) begin
      repeat (9) tick();
      chk("r5_busy_settle", 32'(busy), 32'(k <= 7));
      cic_pulse(k == 8);
    end
    chk("r5_cur_rate", current_rate, 32'd5);
    chk("r5_drop", 32'(drop_cnt), 32'd0);

    // change to 7 with strobes in HOLD, then held request 3
    req(32'd7, h);
    s_tdata  = 32'd3;
    s_tvalid = 1'b1;
    repeat (2) tick();
    b = cyc;
    rate_q.push_back('{32'd7, b + 5});
    for (int i = 0; i < 6; i++) begin
      in_tvalid_i = 1'b1;
      in_q.push_back(i == 0 || i == 5);
      if (i == 0) begin
        out_q.push_back(1'b1);
        cic_out_tvalid_i = 1'b1;
      end
      if (i == 2) chk("r7_tready_hold", 32'(s_tready), 32'd0);
      tick();
      cic_out_tvalid_i = 1'b0;
    end
    in_tvalid_i = 1'b0;
    chk("r7_drop", 32'(drop_cnt), 32'd4);
    for (int k = 0; k < 7; k++) begin
      chk("r7_tready_settle", 32'(s_tready), 32'd0);
      cic_pulse(1'b0);
      if (k < 6) tick();
    end
    chk("r7_tready_idle", 32'(s_tready), 32'd1);
    tick();
    s_tvalid = 1'b0;
    chk("r3_busy", 32'(busy), 32'd1);
    chk("r7_cur_rate", current_rate, 32'd7);
    repeat (2) tick();
    b = cyc;
    rate_q.push_back('{32'd3, b + 5});
    cic_pulse(1'b1);
    repeat (6) tick();
    for (int k = 0; k < 7; k++) begin
      cic_pulse(1'b0);
      tick();
    end
    chk("r3_busy_done", 32'(busy), 32'd0);
    chk("r3_cur_rate", current_rate, 32'd3);

    // reset while in SETTLE
    req(32'd8, h);
    tick();
    b = cyc;
    rate_q.push_back('{32'd8, b + 5});
    cic_pulse(1'b1);
    repeat (6) tick();
    cic_pulse(1'b0);
    chk("r8_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tready", 32'(s_tready), 32'd0);
    chk("mid_rst_cur", current_rate, 32'd10);
    chk("mid_rst_tdata", m_axis_rate_tdata, 32'd10);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("mid_rst_tready_up", 32'(s_tready), 32'd1);
    cic_pulse(1'b1);

`ifdef CIC_RATE_CTRL_TIMEOUT_EN
    req(32'd6, h);
    rate_q.push_back('{32'd6, h + 4101});
    tc = -1;
    for (int i = 0; i < 5000 && tc < 0; i++) begin
      if (timeout_evt) tc = cyc;
      else tick();
    end
    chk("timeout_cycle", 32'(tc), 32'(h + 4097));
    repeat (6) tick();
    for (int k = 0; k < 7; k++) begin
      cic_pulse(1'b0);
      tick();
    end
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_cur_rate", current_rate, 32'd6);
`else
    tc = 0;
`endif

    repeat (3) tick();
    chk("rate_q_empty", 32'(rate_q.size()), 32'd0);
    chk("err_q_empty", 32'(err_q.size()), 32'd0);
    chk("out_q_empty", 32'(out_q.size()), 32'd0);
    chk("in_q_empty", 32'(in_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
